slave_link_responder: RTL and testbench

Slave-board end of the master/slave UART game link. Consumes byte frames the master pushes (load, attack, clear) and judges each attack against the slave player's latched ship map. Maintains the attack history and the remaining lives, and returns a 2-byte status frame to the master. Sits between the slave's UART RX/TX byte engines and the slave's switch and LED logic.

---
 rtl/battleship_link_pkg.sv | 35 +++
 rtl/link_frame_rx.sv | 80 ++++++++
 rtl/slave_link_responder.sv | 150 +++++++++++++++
 tb/tb_slave_link_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/battleship_link_pkg.sv
// rtl/battleship_link_pkg.sv - shared types, command codes and helpers for the slave game link
package battleship_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DHI,
    ST_DLO,
    ST_CHK,
    ST_EVAL,
    ST_TX_SOF,
    ST_TX_STAT
  } link_state_t;

  localparam logic [7:0] CMD_LOAD   = 8'h01;
  localparam logic [7:0] CMD_ATTACK = 8'h02;
  localparam logic [7:0] CMD_CLEAR  = 8'h03;

  typedef struct packed {
    logic       ok;
    logic       hit;
    logic       game_over;
    logic [4:0] lives;
  } status_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/link_frame_rx.sv
// rtl/link_frame_rx.sv - SOF hunt, byte capture, checksum and inter-byte timeout for inbound frames
module link_frame_rx
  import battleship_link_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter logic [7:0]  SOF_RX      = 8'hA5
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        i_enable,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_frame_valid,
  output logic [7:0]  o_cmd,
  output logic [15:0] o_data,
  output logic        o_chk_ok,
  output logic        o_timeout
);

  localparam logic [19:0] GAP_LAST = 20'(TIMEOUT_CYC - 1);

  link_state_t r_state, w_next;
  logic [19:0] r_gap;
  logic [7:0]  r_cmd, r_dhi, r_dlo;
  logic        r_frame_valid, r_chk_ok, r_timeout;
  logic        w_byte, w_gap_expired;

  assign w_byte        = i_rx_valid && i_enable;
  assign w_gap_expired = (r_state != ST_IDLE) && !w_byte && (r_gap == GAP_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_byte && i_rx_data == SOF_RX) w_next = ST_CMD;
      ST_CMD:  if (w_byte) w_next = ST_DHI; else if (w_gap_expired) w_next = ST_IDLE;
      ST_DHI:  if (w_byte) w_next = ST_DLO; else if (w_gap_expired) w_next = ST_IDLE;
      ST_DLO:  if (w_byte) w_next = ST_CHK; else if (w_gap_expired) w_next = ST_IDLE;
      ST_CHK:  if (w_byte || w_gap_expired) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state       <= ST_IDLE;
      r_gap         <= 20'd0;
      r_cmd         <= 8'h00;
      r_dhi         <= 8'h00;
      r_dlo         <= 8'h00;
      r_frame_valid <= 1'b0;
      r_chk_ok      <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_frame_valid <= 1'b0;
      r_timeout     <= w_gap_expired;
      r_gap         <= (r_state == ST_IDLE || w_byte) ? 20'd0 : r_gap + 20'd1;
      if (w_byte) begin
        case (r_state)
          ST_CMD: r_cmd <= i_rx_data;
          ST_DHI: r_dhi <= i_rx_data;
          ST_DLO: r_dlo <= i_rx_data;
          ST_CHK: begin
            r_frame_valid <= 1'b1;
            r_chk_ok      <= (i_rx_data == (r_cmd ^ r_dhi ^ r_dlo));
          end
          default: ;
        endcase
      end
    end
  end

  // Captured fields hold until the next frame, so the core can read them during EVAL.
  assign o_frame_valid = r_frame_valid;
  assign o_cmd         = r_cmd;
  assign o_data        = {r_dhi, r_dlo};
  assign o_chk_ok      = r_chk_ok;
  assign o_timeout     = r_timeout;

endmodule

// File: rtl/slave_link_responder.sv
// rtl/slave_link_responder.sv - slave end of the UART game link: judges frames and returns status
module slave_link_responder
  import battleship_link_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter logic [7:0]  SOF_RX      = 8'hA5,
  parameter logic [7:0]  SOF_TX      = 8'h5A
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [15:0] ship_sw,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] ship_map,
  output logic [15:0] attack_map,
  output logic [4:0]  lives,
  output logic        hit,
  output logic        ok,
  output logic        game_over,
  output logic        loaded,
  output logic        frame_err
);

  link_state_t r_state, w_next;
  logic        w_frame_valid, w_chk_ok, w_timeout, w_rx_enable;
  logic [7:0]  w_cmd;
  logic [15:0] w_data;
  logic [15:0] r_ship_map, r_attack_map;
  logic [4:0]  r_lives;
  logic        r_hit, r_ok, r_game_over, r_loaded, r_frame_err;
  logic [15:0] w_new;
  logic [4:0]  w_load_lives;
  logic        w_legal, w_hit_now, w_cmd_known;
  status_t     w_status;

  // Bytes arriving while a frame is being judged or answered are dropped.
  assign w_rx_enable = (r_state == ST_IDLE) && !w_frame_valid;

  link_frame_rx #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SOF_RX      (SOF_RX)
  ) u_rx (
    .clk           (clk),
    .clr_n         (clr_n),
    .i_enable      (w_rx_enable),
    .i_rx_data     (rx_data),
    .i_rx_valid    (rx_valid),
    .o_frame_valid (w_frame_valid),
    .o_cmd         (w_cmd),
    .o_data        (w_data),
    .o_chk_ok      (w_chk_ok),
    .o_timeout     (w_timeout)
  );

  assign w_cmd_known  = (w_cmd == CMD_LOAD) || (w_cmd == CMD_ATTACK) || (w_cmd == CMD_CLEAR);
  assign w_load_lives = popcount16(ship_sw);
  assign w_new        = w_data & ~r_attack_map;
  assign w_hit_now    = |(w_new & r_ship_map);
  // An attack must keep every earlier shot and add exactly one new cell.
  assign w_legal      = r_loaded && !r_game_over && ((r_attack_map & ~w_data) == 16'h0000)
                        && (popcount16(w_new) == 5'd1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_frame_valid) w_next = ST_EVAL;
      ST_EVAL:    w_next = ST_TX_SOF;
      ST_TX_SOF:  if (tx_ready) w_next = ST_TX_STAT;
      ST_TX_STAT: if (tx_ready) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_ship_map   <= 16'h0000;
      r_attack_map <= 16'h0000;
      r_lives      <= 5'd0;
      r_hit        <= 1'b0;
      r_ok         <= 1'b0;
      r_game_over  <= 1'b0;
      r_loaded     <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_err <= w_timeout;
      if (r_state == ST_EVAL) begin
        if (!w_chk_ok || !w_cmd_known) begin
          r_frame_err <= 1'b1;
          r_ok        <= 1'b0;
        end else if (w_cmd == CMD_LOAD) begin
          r_ship_map   <= ship_sw;
          r_lives      <= w_load_lives;
          r_attack_map <= 16'h0000;
          r_hit        <= 1'b0;
          r_game_over  <= 1'b0;
          r_loaded     <= (w_load_lives != 5'd0);
          r_ok         <= (w_load_lives != 5'd0);
        end else if (w_cmd == CMD_ATTACK) begin
          r_ok  <= w_legal;
          r_hit <= w_legal && w_hit_now;
          if (w_legal) begin
            r_attack_map <= w_data;
            if (w_hit_now) begin
              r_lives <= r_lives - 5'd1;
              if (r_lives == 5'd1) r_game_over <= 1'b1;
            end
          end
        end else begin
          r_ship_map   <= 16'h0000;
          r_attack_map <= 16'h0000;
          r_lives      <= 5'd0;
          r_hit        <= 1'b0;
          r_game_over  <= 1'b0;
          r_loaded     <= 1'b0;
          r_ok         <= 1'b1;
        end
      end
    end
  end

  assign w_status = '{ok: r_ok, hit: r_hit, game_over: r_game_over, lives: r_lives};

  always_comb begin
    tx_data = 8'h00;
    case (r_state)
      ST_TX_SOF:  tx_data = SOF_TX;
      ST_TX_STAT: tx_data = w_status;
      default:    tx_data = 8'h00;
    endcase
  end

  assign tx_valid   = (r_state == ST_TX_SOF) || (r_state == ST_TX_STAT);
  assign ship_map   = r_ship_map;
  assign attack_map = r_attack_map;
  assign lives      = r_lives;
  assign hit        = r_hit;
  assign ok         = r_ok;
  assign game_over  = r_game_over;
  assign loaded     = r_loaded;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_slave_link_responder.sv
// tb/tb_slave_link_responder.sv - randomized self-checking bench for slave_link_responder
module tb_slave_link_responder;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] ship_sw = 16'h0000;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [15:0] ship_map, attack_map;
  logic [4:0]  lives;
  logic        hit, ok, game_over, loaded, frame_err;

  slave_link_responder #(.TIMEOUT_CYC(TO), .SOF_RX(8'hA5), .SOF_TX(8'h5A)) dut (
    .clk(clk), .clr_n(clr_n), .rx_data(rx_data), .rx_valid(rx_valid), .ship_sw(ship_sw),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ship_map(ship_map), .attack_map(attack_map), .lives(lives), .hit(hit), .ok(ok),
    .game_over(game_over), .loaded(loaded), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;

  always @(negedge clk) if (frame_err) err_cnt++;

  // Behavioural game state
  logic [15:0] m_ship, m_amap;
  logic [4:0]  m_lives;
  logic        m_hit, m_ok, m_go, m_loaded;

  logic [7:0] bp [5] = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h01};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ship = 0; m_amap = 0; m_lives = 0; m_hit = 0; m_ok = 0; m_go = 0; m_loaded = 0;
  endtask

  task automatic model_eval(input logic [7:0] cmd, input logic [15:0] d, input logic [7:0] chk,
                            output logic exp_err);
    logic [15:0] nw;
    exp_err = 1'b0;
    if (chk != (cmd ^ d[15:8] ^ d[7:0]) || !(cmd inside {8'h01, 8'h02, 8'h03})) begin
      exp_err = 1'b1;
      m_ok = 1'b0;
    end else if (cmd == 8'h01) begin
      m_ship = ship_sw; m_lives = 5'($countones(ship_sw)); m_amap = 0; m_hit = 0; m_go = 0;
      m_loaded = (m_lives != 0); m_ok = m_loaded;
    end else if (cmd == 8'h02) begin
      nw = d & ~m_amap;
      if (m_loaded && !m_go && (m_amap & ~d) == 0 && $countones(nw) == 1) begin
        m_amap = d; m_hit = ((nw & m_ship) != 0); m_ok = 1'b1;
        if (m_hit) begin
          m_lives = m_lives - 1;
          if (m_lives == 0) m_go = 1'b1;
        end
      end else begin
        m_ok = 1'b0; m_hit = 1'b0;
      end
    end else begin
      model_reset();
      m_ok = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [15:0] d, input logic [7:0] chk,
                            input int gap);
    logic [7:0] b [4];
    b[0] = cmd; b[1] = d[15:8]; b[2] = d[7:0]; b[3] = chk;
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) begin
      repeat (gap) @(negedge clk);
      send_byte(b[i]);
    end
  endtask

  task automatic get_response(output logic [7:0] b0, output logic [7:0] b1, output int n);
    int pct;
    pct = int'($urandom_range(100, 30));
    n = 0; b0 = 0; b1 = 0;
    for (int c = 0; c < 200 && n < 2; c++) begin
      @(negedge clk);
      tx_ready = (int'($urandom_range(99)) < pct);
      if (tx_valid && tx_ready) begin
        if (n == 0) b0 = tx_data; else b1 = tx_data;
        n++;
      end
    end
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [7:0] stat, input logic exp_err,
                             input int e0);
    check({tag, "_stat"}, stat, {m_ok, m_hit, m_go, m_lives});
    check({tag, "_ferr"}, err_cnt - e0, 32'(exp_err));
    check({tag, "_maps"}, {ship_map, attack_map}, {m_ship, m_amap});
    check({tag, "_flags"}, {lives, hit, ok, game_over, loaded}, {m_lives, m_hit, m_ok, m_go, m_loaded});
  endtask

  task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [15:0] d,
                           input logic [7:0] chk, input int gap, output logic [7:0] stat);
    int e0, n;
    logic exp_err;
    logic [7:0] b0;
    e0 = err_cnt;
    send_frame(cmd, d, chk, gap);
    model_eval(cmd, d, chk, exp_err);
    get_response(b0, stat, n);
    check({tag, "_nbytes"}, n, 2);
    check({tag, "_sof"}, b0, 8'h5A);
    check_state(tag, stat, exp_err, e0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_txv"}, tx_valid, 0);
    check({tag, "_maps"}, {ship_map, attack_map}, 0);
    check({tag, "_outs"}, {lives, hit, ok, game_over, loaded, frame_err, tx_data}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] stat, b0, cmd, chk;
    logic [15:0] d;
    logic exp_err, seen;
    int e0, n, sel;

    model_reset();
    repeat (3) @(negedge clk);
    check_cleared("reset");
    clr_n = 1'b1;

    // Load with first-response latency and back-pressure on the SOF byte
    ship_sw = 16'h30E6;
    e0 = err_cnt;
    send_frame(8'h01, 16'h0000, 8'h01, 0);
    model_eval(8'h01, 16'h0000, 8'h01, exp_err);
    @(negedge clk);
    check("lat_n1_valid", tx_valid, 0);
    @(negedge clk);
    check("lat_n2_valid", tx_valid, 1);
    check("lat_n2_sof", tx_data, 8'h5A);
    check("lat_n2_lives", lives, 7);
    for (int i = 0; i < 5; i++) begin
      send_byte(bp[i]);
      check("bp_valid", tx_valid, 1);
      check("bp_data", tx_data, 8'h5A);
    end
    get_response(b0, stat, n);
    check("load_nbytes", n, 2);
    check("load_sof", b0, 8'h5A);
    check("load_lit", stat, 8'h87);
    check_state("load", stat, exp_err, e0);
    seen = 0;
    repeat (10) begin @(negedge clk); if (tx_valid) seen = 1; end
    check("dropped_frame_no_tx", seen, 0);

    run_frame("miss", 8'h02, 16'h8000, 8'h82, 0, stat);  check("miss_lit", stat, 8'h87);
    run_frame("hit", 8'h02, 16'hA000, 8'hA2, 0, stat);   check("hit_lit", stat, 8'hC6);
    check("hit_amap", attack_map, 16'hA000);
    run_frame("two_new", 8'h02, 16'hA003, 8'hA1, 0, stat); check("two_new_lit", stat, 8'h06);
    run_frame("remove", 8'h02, 16'h2000, 8'h22, 0, stat);  check("remove_lit", stat, 8'h06);
    run_frame("badchk", 8'h02, 16'hC000, 8'h00, 0, stat);  check("badchk_lit", stat, 8'h06);

    // Inter-byte timeout: no response, one error pulse
    e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h02);
    seen = 0;
    repeat (TO + 10) begin @(negedge clk); if (tx_valid) seen = 1; end
    check("to_ferr", err_cnt - e0, 1);
    check("to_no_tx", seen, 0);
    run_frame("gap_edge", 8'h02, 16'hA001, 8'hA3, TO - 4, stat); check("gap_edge_lit", stat, 8'h86);

    ship_sw = 16'h0001;
    run_frame("go_load", 8'h01, 16'h0000, 8'h01, 0, stat); check("go_load_lit", stat, 8'h81);
    run_frame("go_hit", 8'h02, 16'h0001, 8'h03, 0, stat);  check("go_hit_lit", stat, 8'hE0);
    run_frame("go_again", 8'h02, 16'h0001, 8'h03, 0, stat); check("go_again_lit", stat, 8'h20);
    run_frame("clear", 8'h03, 16'h0000, 8'h03, 0, stat);   check("clear_lit", stat, 8'h80);

    // Reset while the status byte is on the wire
    ship_sw = 16'h30E6;
    send_frame(8'h01, 16'h0000, 8'h01, 0);
    model_eval(8'h01, 16'h0000, 8'h01, exp_err);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); if (tx_valid) seen = 1; end
    check("rst_mid_wait", seen, 1);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check("rst_mid_stat", tx_data, 8'h87);
    clr_n = 1'b0;
    @(negedge clk);
    check_cleared("rst_mid");
    clr_n = 1'b1;
    model_reset();

    for (int f = 0; f < 150; f++) begin
      sel = int'($urandom_range(9));
      d = 16'($urandom);
      if (sel < 2) begin
        cmd = 8'h01;
        case ($urandom_range(3))
          0: ship_sw = 16'h0000;
          1: ship_sw = (16'd1 << $urandom_range(15)) | (16'd1 << $urandom_range(15));
          default: ship_sw = 16'($urandom);
        endcase
      end else if (sel < 7) begin
        cmd = 8'h02;
        if ($urandom_range(3) != 0) d = m_amap | (16'd1 << $urandom_range(15));
      end else if (sel == 7) begin
        cmd = 8'h03;
      end else begin
        cmd = 8'($urandom_range(255));
      end
      chk = cmd ^ d[15:8] ^ d[7:0];
      if ($urandom_range(9) == 0) chk = chk ^ (8'd1 << $urandom_range(7));
      run_frame("rnd", cmd, d, chk, 0, stat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
